neuron_learn_layer_seq: RTL and testbench

Parametrised, time-multiplexed successor to the fixed 25-neuron learning layer. It holds an M x N weight matrix internally and shares one multiply-accumulate datapath across all neurons and inputs. It runs a forward pass and, optionally, an in-place weight update with back-projected averaged expected_in. It sits between layers in the network and uses valid/ready handshakes on both sides, so layers can be chained with back-pressure.

---
 rtl/neuron_learn_layer_seq.sv | 204 ++++++++++++++++++++
 tb/tb_neuron_learn_layer_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_learn_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_learn_layer_seq
//  Purpose  : Time-multiplexed M x N learning layer: forward pass plus optional
//             in-place weight update and averaged back-projection of targets.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_learn_layer_seq #(
    parameter int N        = 16,
    parameter int M        = 25,
    parameter int LR_SHIFT = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                learn,
    input  logic [N*16-1:0]     in,
    input  logic [M*16-1:0]     expected_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M*16-1:0]     out,
    output logic [N*16-1:0]     expected_in,
    output logic [M*N*16-1:0]   weights,
    output logic [M*16-1:0]     activation_max,
    output logic [M*16-1:0]     activation_min
);
    // Both frac_t (signed) and zero2one_t (unsigned) use 14 fractional bits: 1.0 = 16384.
    localparam int c_W  = 16;
    localparam int c_FB = 14;
    localparam logic signed [c_W-1:0] c_RECIP_M = c_W'(16384 / M);
    localparam int c_IW = (N > 1) ? $clog2(N) : 1;
    localparam int c_JW = (M > 1) ? $clog2(M) : 1;
    localparam int c_PW = 2*c_W + 1;
    localparam int c_AW = c_PW + c_IW + 1;
    localparam int c_BW = 2*c_W + c_JW + 1;
    localparam int c_SW = c_BW + c_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_UPD  = 3'd2,
        S_AVG  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [N*c_W-1:0]           r_in;
    logic [M*c_W-1:0]           r_exp;
    logic                       r_learn;
    logic [c_IW-1:0]            r_i;
    logic [c_JW-1:0]            r_j;
    logic signed [c_AW-1:0]     r_acc;
    logic signed [c_BW-1:0]     r_backsum [N];
    logic [M*c_W-1:0]           r_out;
    logic [M*c_W-1:0]           r_act_max;
    logic [M*c_W-1:0]           r_act_min;
    logic [N*c_W-1:0]           r_exp_in;
    logic [M*N*c_W-1:0]         r_weights;

    int                         w_idx;
    logic                       w_last_i;
    logic                       w_last_j;
    logic signed [c_W-1:0]      w_wt;
    logic signed [c_W-1:0]      w_err;
    logic signed [c_W:0]        w_x;
    logic signed [c_PW-1:0]     w_prod_fwd;
    logic signed [c_AW-1:0]     w_acc_next;
    logic signed [c_AW-1:0]     w_sum;
    logic [c_W-1:0]             w_sum_sat;
    logic [c_W-1:0]             w_sum_unit;
    logic signed [2*c_W-1:0]    w_prod_bs;
    logic signed [c_PW-1:0]     w_prod_upd;
    logic [c_W-1:0]             w_wt_new;
    logic [c_W-1:0]             w_exp_in_next [N];

    function automatic logic [c_W-1:0] sat_frac(input logic signed [63:0] v);
        if (v > 64'sd32767)       return 16'h7fff;
        else if (v < -64'sd32768) return 16'h8000;
        else                      return v[c_W-1:0];
    endfunction

    function automatic logic [c_W-1:0] clamp_unit(input logic signed [63:0] v);
        if (v > 64'sd16384)     return 16'h4000;
        else if (v < 64'sd0)    return 16'h0000;
        else                    return v[c_W-1:0];
    endfunction

    always_comb begin
        w_idx      = int'(r_j) * N + int'(r_i);
        w_last_i   = (r_i == c_IW'(N-1));
        w_last_j   = (r_j == c_JW'(M-1));
        w_wt       = $signed(r_weights[w_idx*c_W +: c_W]);
        w_x        = $signed({1'b0, r_in[int'(r_i)*c_W +: c_W]});
        w_err      = $signed(sat_frac(64'($signed({1'b0, r_exp[int'(r_j)*c_W +: c_W]}))
                                    - 64'($signed({1'b0, r_out[int'(r_j)*c_W +: c_W]}))));
        w_prod_fwd = c_PW'(w_wt) * c_PW'(w_x);
        w_acc_next = r_acc + c_AW'(w_prod_fwd);
        w_sum      = w_acc_next >>> c_FB;
        w_sum_sat  = sat_frac(64'(w_sum));
        w_sum_unit = clamp_unit(64'(w_sum));
        // Back-projection uses the weight as it stands before this cycle's update.
        w_prod_bs  = (2*c_W)'(w_wt) * (2*c_W)'(w_err);
        w_prod_upd = c_PW'(w_err) * c_PW'(w_x);
        w_wt_new   = sat_frac(64'(w_wt) + 64'(w_prod_upd >>> (c_FB + LR_SHIFT)));
    end

    for (genvar g = 0; g < N; g++) begin : g_avg
        logic signed [c_SW-1:0] w_scaled;
        assign w_scaled = c_SW'(r_backsum[g]) * c_SW'(c_RECIP_M);
        assign w_exp_in_next[g] = clamp_unit(64'($signed({1'b0, r_in[g*c_W +: c_W]}))
                                             + 64'(w_scaled >>> (2*c_FB)));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_FWD;
            S_FWD:   if (w_last_i && w_last_j) w_state_next = r_learn ? S_UPD : S_DONE;
            S_UPD:   if (w_last_i && w_last_j) w_state_next = S_AVG;
            S_AVG:   w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in      <= '0;
            r_exp     <= '0;
            r_learn   <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_out     <= '0;
            r_act_max <= '0;
            r_act_min <= '0;
            r_exp_in  <= '0;
            r_weights <= '0;
            for (int k = 0; k < N; k++) r_backsum[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in    <= in;
                        r_exp   <= expected_out;
                        r_learn <= learn;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_acc   <= '0;
                    end
                end
                S_FWD: begin
                    if (w_last_i) begin
                        r_acc <= '0;
                        r_out[int'(r_j)*c_W +: c_W] <= w_sum_unit;
                        if ($signed(w_sum_sat) > $signed(r_act_max[int'(r_j)*c_W +: c_W]))
                            r_act_max[int'(r_j)*c_W +: c_W] <= w_sum_sat;
                        if ($signed(w_sum_sat) < $signed(r_act_min[int'(r_j)*c_W +: c_W]))
                            r_act_min[int'(r_j)*c_W +: c_W] <= w_sum_sat;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end
                S_UPD: begin
                    r_weights[w_idx*c_W +: c_W] <= w_wt_new;
                    r_backsum[r_i] <= r_backsum[r_i] + c_BW'(w_prod_bs);
                end
                S_AVG: begin
                    for (int k = 0; k < N; k++) begin
                        r_exp_in[k*c_W +: c_W] <= w_exp_in_next[k];
                        r_backsum[k]           <= '0;
                    end
                end
                default: ;
            endcase

            if (r_state == S_FWD || r_state == S_UPD) begin
                if (w_last_i) begin
                    r_i <= '0;
                    r_j <= w_last_j ? '0 : r_j + c_JW'(1);
                end else begin
                    r_i <= r_i + c_IW'(1);
                end
            end
        end
    end

    assign in_ready       = (r_state == S_IDLE);
    assign out_valid      = (r_state == S_DONE);
    assign out            = r_out;
    assign expected_in    = r_exp_in;
    assign weights        = r_weights;
    assign activation_max = r_act_max;
    assign activation_min = r_act_min;

endmodule
`default_nettype wire

// File: tb/tb_neuron_learn_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_learn_layer_seq
//  Purpose  : Directed self-checking bench for neuron_learn_layer_seq (N=2, M=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_learn_layer_seq;
    localparam int N = 2;
    localparam int M = 2;
    localparam int LR_SHIFT = 0;
    localparam int W = 16;
    localparam longint ONE = 16384;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               learn = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic [N*W-1:0]     in_vec = '0;
    logic [M*W-1:0]     exp_out = '0;
    logic [M*W-1:0]     out_vec;
    logic [N*W-1:0]     expected_in;
    logic [M*N*W-1:0]   weights;
    logic [M*W-1:0]     act_max;
    logic [M*W-1:0]     act_min;

    int n_checks = 0;
    int n_errors = 0;

    longint m_w [M][N];
    longint m_out [M];
    longint m_amax [M];
    longint m_amin [M];
    longint m_ei [N];

    neuron_learn_layer_seq #(.N(N), .M(M), .LR_SHIFT(LR_SHIFT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .learn          (learn),
        .in             (in_vec),
        .expected_out   (exp_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out            (out_vec),
        .expected_in    (expected_in),
        .weights        (weights),
        .activation_max (act_max),
        .activation_min (act_min)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint unit(input longint v);
        if (v > ONE) return ONE;
        if (v < 0) return 0;
        return v;
    endfunction

    function automatic logic [127:0] pk_m(input longint a [M]);
        logic [127:0] r = '0;
        for (int j = 0; j < M; j++) r[j*W +: W] = W'(a[j]);
        return r;
    endfunction

    function automatic logic [127:0] pk_n(input longint a [N]);
        logic [127:0] r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
        return r;
    endfunction

    function automatic logic [127:0] pk_w();
        logic [127:0] r = '0;
        for (int j = 0; j < M; j++)
            for (int i = 0; i < N; i++) r[(j*N+i)*W +: W] = W'(m_w[j][i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < M; j++) begin
            m_out[j] = 0; m_amax[j] = 0; m_amin[j] = 0;
            for (int i = 0; i < N; i++) m_w[j][i] = 0;
        end
        for (int i = 0; i < N; i++) m_ei[i] = 0;
    endtask

    // Whole-transaction reference: dot products, clamps, delta rule, averaged back-projection.
    task automatic model_pass(input logic [N*W-1:0] x, input logic lrn, input logic [M*W-1:0] e);
        longint xi [N];
        longint bs [N];
        longint s;
        longint err;
        for (int i = 0; i < N; i++) begin
            xi[i] = longint'(x[i*W +: W]);
            bs[i] = 0;
        end
        for (int j = 0; j < M; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += m_w[j][i] * xi[i];
            s = s >>> 14;
            if (sat(s) > m_amax[j]) m_amax[j] = sat(s);
            if (sat(s) < m_amin[j]) m_amin[j] = sat(s);
            m_out[j] = unit(s);
        end
        if (lrn) begin
            for (int j = 0; j < M; j++) begin
                err = sat(longint'(e[j*W +: W]) - m_out[j]);
                for (int i = 0; i < N; i++) begin
                    bs[i] += m_w[j][i] * err;
                    m_w[j][i] = sat(m_w[j][i] + ((err * xi[i]) >>> (14 + LR_SHIFT)));
                end
            end
            for (int i = 0; i < N; i++)
                m_ei[i] = unit(xi[i] + ((bs[i] * (ONE / M)) >>> 28));
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            check("done_out", out_vec, pk_m(m_out));
            check("done_expected_in", expected_in, pk_n(m_ei));
            check("done_weights", weights, pk_w());
            check("done_act_max", act_max, pk_m(m_amax));
            check("done_act_min", act_min, pk_m(m_amin));
            check("done_in_ready", in_ready, 0);
        end
    end

    task automatic run(input logic [N*W-1:0] x, input logic lrn, input logic [M*W-1:0] e,
                       input int hold);
        int cyc;
        @(negedge clock);
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        in_vec = x; learn = lrn; exp_out = e; in_valid = 1'b1;
        @(posedge clock);
        model_pass(x, lrn, e);
        #1;
        in_valid = 1'b0; in_vec = ~x; exp_out = ~e; learn = ~lrn;
        cyc = 1;
        @(negedge clock);
        while (!out_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("latency", 128'(cyc), lrn ? 128'(2*M*N+2) : 128'(M*N+1));
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_vec = N*W'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("in_reset_in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out_vec, 0);
        check("rst_expected_in", expected_in, 0);
        check("rst_weights", weights, 0);
        check("rst_act_max", act_max, 0);
        check("rst_act_min", act_min, 0);

        run(32'h2000_2000, 1'b0, 32'h0, 0);
        check("fwd0_out_lit", out_vec, 32'h0);
        check("fwd0_ei_lit", expected_in, 32'h0);

        run(32'h2000_2000, 1'b1, 32'h4000_4000, 0);
        check("learn1_w_lit", weights, 64'h2000_2000_2000_2000);
        check("learn1_ei_lit", expected_in, 32'h2000_2000);

        run(32'h2000_2000, 1'b0, 32'h0, 0);
        check("fwd1_out_lit", out_vec, 32'h2000_2000);
        check("fwd1_amax_lit", act_max, 32'h2000_2000);

        run(32'h2000_2000, 1'b1, 32'h4000_4000, 20);
        check("learn2_w_lit", weights, 64'h3000_3000_3000_3000);
        check("learn2_ei_lit", expected_in, 32'h3000_3000);

        for (int k = 0; k < 3; k++) run(32'h4000_4000, 1'b1, 32'hFFFF_FFFF, 0);
        check("sat_w_lit", weights, 64'h7FFF_7FFF_7FFF_7FFF);
        check("sat_out_lit", out_vec, 32'h4000_4000);

        for (int k = 0; k < 3; k++) run(32'h4000_4000, 1'b1, 32'h0, 0);
        run(32'h4000_4000, 1'b0, 32'h0, 0);
        check("neg_w_lit", weights, 64'hFFFF_FFFF_FFFF_FFFF);
        check("neg_out_lit", out_vec, 32'h0);
        check("neg_amin_lit", act_min, 32'hFFFE_FFFE);

        @(negedge clock);
        in_vec = 32'h2000_2000; learn = 1'b1; exp_out = 32'h4000_4000; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_weights", weights, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_act_max", act_max, 0);
        check("abort_act_min", act_min, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_in_ready", in_ready, 1);

        run(32'h2000_2000, 1'b0, 32'h0, 0);
        check("post_abort_out_lit", out_vec, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
